// File: rtl/load_store_unit.sv
// Load/store unit: maps RV32I byte-address loads and stores onto a 32-bit word memory that has no byte enables.
// Define LSU_ALIGN_CHECK_EN to report misaligned halfword/word accesses as errors instead of ignoring the low address bits.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] LP_MEM_WORDS = 32'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_illegal;
    logic        w_range_err;
    logic        w_misalign;
    logic        w_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;

    assign w_accept = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_illegal = 1'b0;
        if (req_we) begin
            w_illegal = (req_funct3 >= 3'b011);
        end else begin
            w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
        end
    end

    assign w_range_err = ({2'b00, req_addr[31:2]} >= LP_MEM_WORDS);

`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        w_misalign = 1'b0;
        if (req_funct3[1:0] == 2'b01) begin
            w_misalign = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            w_misalign = (req_addr[1:0] != 2'b00);
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = w_illegal || w_range_err || w_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_next_state = S_RESP;
                    end else if (!req_we) begin
                        w_next_state = S_LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        w_next_state = S_WRITE;
                    end else begin
                        w_next_state = S_MERGE;
                    end
                end
            end
            S_LOAD:  w_next_state = S_RESP;
            S_MERGE: w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Halfword selection uses only addr[1]; addr[0] is either rejected earlier or deliberately ignored.
    always_comb begin
        w_byte = 8'h00;
        case (r_addr_lo)
            2'b00: w_byte = mem_rdata[7:0];
            2'b01: w_byte = mem_rdata[15:8];
            2'b10: w_byte = mem_rdata[23:16];
            2'b11: w_byte = mem_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_val = {24'h000000, w_byte};
            3'b101:  w_load_val = {16'h0000, w_half};
            default: w_load_val = mem_rdata;
        endcase
    end

    // r_mem_wdata holds rs2 from acceptance until MERGE overwrites it with the merged word.
    always_comb begin
        w_merged = mem_rdata;
        if (r_funct3[0] == 1'b0) begin
            w_merged[{r_addr_lo, 3'b000} +: 8] = r_mem_wdata[7:0];
        end else begin
            w_merged[{r_addr_lo[1], 4'b0000} +: 16] = r_mem_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3  <= req_funct3;
                        r_addr_lo <= req_addr[1:0];
                        if (w_err) begin
                            r_resp_rdata <= 32'h0;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_mem_addr <= {2'b00, req_addr[31:2]};
                            if (req_we) begin
                                r_mem_wdata <= req_wdata;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_resp_rdata <= w_load_val;
                    r_resp_err   <= 1'b0;
                end
                S_MERGE: begin
                    r_mem_wdata <= w_merged;
                end
                S_WRITE: begin
                    r_resp_rdata <= 32'h0;
                    r_resp_err   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign mem_we     = (r_state == S_WRITE);
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases from the feature list plus randomized back-to-back traffic against a reference model.
// Honours LSU_ALIGN_CHECK_EN the same way the design does.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem    [0:255];
    logic [31:0] refMem [0:255];
    logic        preloadEn;
    logic        clearEn;
    logic [7:0]  preloadIdx;
    logic [31:0] preloadData;

    int passCount;
    int checkCount;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (clearEn) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (preloadEn) begin
            mem[preloadIdx] <= preloadData;
        end else if (mem_we && (mem_addr < 32'd256)) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic clearMem();
        @(negedge clk);
        clearEn = 1'b1;
        @(posedge clk);
        #1 clearEn = 1'b0;
        for (int i = 0; i < 256; i++) refMem[i] = 32'h0;
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clk);
        preloadIdx  = idx[7:0];
        preloadData = data;
        preloadEn   = 1'b1;
        @(posedge clk);
        #1 preloadEn = 1'b0;
        refMem[idx] = data;
    endtask

    // Reference behaviour: what the response, latency and write activity should be, and the memory afterwards.
    task automatic modelTxn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] expRdata,
                            output logic expErr, output int expLat, output int expWeCnt);
        int   idx;
        int   bsel;
        int   hsel;
        logic bad;
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        idx  = int'(addr >> 2);
        bsel = int'(addr[1:0]);
        hsel = int'(addr[1]);
        bad  = we ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if ((addr >> 2) >= 32'd256) bad = 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) bad = 1'b1;
        if (f3 == 3'd2 && addr[1:0] != 2'b00) bad = 1'b1;
`endif
        expRdata = 32'h0;
        expErr   = bad;
        expWeCnt = 0;
        if (bad) begin
            expLat = 1;
        end else if (!we) begin
            expLat = 2;
            word = refMem[idx];
            b = word[8*bsel +: 8];
            h = word[16*hsel +: 16];
            case (f3)
                3'd0:    expRdata = {{24{b[7]}}, b};
                3'd1:    expRdata = {{16{h[15]}}, h};
                3'd4:    expRdata = {24'h0, b};
                3'd5:    expRdata = {16'h0, h};
                default: expRdata = word;
            endcase
        end else begin
            expWeCnt = 1;
            case (f3)
                3'd0:    begin expLat = 3; refMem[idx][8*bsel +: 8]   = wdata[7:0]; end
                3'd1:    begin expLat = 3; refMem[idx][16*hsel +: 16] = wdata[15:0]; end
                default: begin expLat = 2; refMem[idx] = wdata; end
            endcase
        end
    endtask

    // Drives one request and watches the DUT until its response (bounded to 8 cycles).
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output logic err, output int lat, output int weCnt,
                                 output int weCyc, output logic [31:0] weAddr, output int readyBad);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        rdata = 32'h0; err = 1'b0; lat = -1; weCnt = 0; weCyc = -1; weAddr = 32'hFFFFFFFF; readyBad = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (req_ready) readyBad++;
            if (mem_we) begin
                weCnt++;
                weCyc  = c;
                weAddr = mem_addr;
            end
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        checkCount += 7;
        if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready got %0b want 1", req_ready); else passCount++;
        if (resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid got %0b want 0", resp_valid); else passCount++;
        if (resp_rdata !== 32'h0) $display("[TB] FAIL reset_resp_rdata got %h want 0", resp_rdata); else passCount++;
        if (resp_err !== 1'b0) $display("[TB] FAIL reset_resp_err got %0b want 0", resp_err); else passCount++;
        if (mem_addr !== 32'h0) $display("[TB] FAIL reset_mem_addr got %h want 0", mem_addr); else passCount++;
        if (mem_wdata !== 32'h0) $display("[TB] FAIL reset_mem_wdata got %h want 0", mem_wdata); else passCount++;
        if (mem_we !== 1'b0) $display("[TB] FAIL reset_mem_we got %0b want 0", mem_we); else passCount++;
    endtask

    task automatic test_loads();
        logic [31:0] addrs [4];
        logic [2:0]  f3s   [4];
        logic [31:0] wants [4];
        logic [31:0] rd; logic er; int lat, wc, wcy, rb; logic [31:0] wa;
        logic [31:0] er2; logic ee; int el, ew;
        addrs = '{32'h15, 32'h15, 32'h16, 32'h14};
        f3s   = '{3'd0, 3'd4, 3'd1, 3'd5};
        wants = '{32'hFFFFFFF2, 32'h000000F2, 32'hFFFF8081, 32'h0000F2A3};
        preload(5, 32'h8081F2A3);
        for (int i = 0; i < 4; i++) begin
            modelTxn(1'b0, f3s[i], addrs[i], 32'h0, er2, ee, el, ew);
            applyStimulus(1'b0, f3s[i], addrs[i], 32'h0, rd, er, lat, wc, wcy, wa, rb);
            checkCount += 5;
            if (rd !== wants[i]) $display("[TB] FAIL load%0d_rdata got %h want %h", i, rd, wants[i]); else passCount++;
            if (er !== 1'b0) $display("[TB] FAIL load%0d_err got %0b want 0", i, er); else passCount++;
            if (lat !== 2) $display("[TB] FAIL load%0d_latency got %0d want 2", i, lat); else passCount++;
            if (wc !== 0) $display("[TB] FAIL load%0d_mem_we got %0d pulses want 0", i, wc); else passCount++;
            if (rb !== 0) $display("[TB] FAIL load%0d_ready_busy got %0d high cycles want 0", i, rb); else passCount++;
        end
    endtask

    task automatic test_subword_stores();
        logic [31:0] rd; logic er; int lat, wc, wcy, rb; logic [31:0] wa;
        logic [31:0] er2; logic ee; int el, ew;
        modelTxn(1'b1, 3'd0, 32'h17, 32'h0000005A, er2, ee, el, ew);
        applyStimulus(1'b1, 3'd0, 32'h17, 32'h0000005A, rd, er, lat, wc, wcy, wa, rb);
        #1;
        checkCount += 6;
        if (mem[5] !== 32'h5A81F2A3) $display("[TB] FAIL sb_word got %h want 5A81F2A3", mem[5]); else passCount++;
        if (wc !== 1) $display("[TB] FAIL sb_we_pulses got %0d want 1", wc); else passCount++;
        if (wcy !== 2) $display("[TB] FAIL sb_we_cycle got %0d want 2", wcy); else passCount++;
        if (lat !== 3) $display("[TB] FAIL sb_latency got %0d want 3", lat); else passCount++;
        if (er !== 1'b0 || rd !== 32'h0) $display("[TB] FAIL sb_resp got err=%0b rdata=%h want 0/0", er, rd); else passCount++;
        if (wa !== 32'd5) $display("[TB] FAIL sb_mem_addr got %0d want 5", wa); else passCount++;
        modelTxn(1'b1, 3'd1, 32'h14, 32'hFFFF1234, er2, ee, el, ew);
        applyStimulus(1'b1, 3'd1, 32'h14, 32'hFFFF1234, rd, er, lat, wc, wcy, wa, rb);
        #1;
        checkCount += 2;
        if (mem[5] !== 32'h5A811234) $display("[TB] FAIL sh_word got %h want 5A811234", mem[5]); else passCount++;
        if (lat !== 3 || wc !== 1) $display("[TB] FAIL sh_timing got lat=%0d pulses=%0d want 3/1", lat, wc); else passCount++;
    endtask

    task automatic test_range();
        logic [31:0] rd; logic er; int lat, wc, wcy, rb; logic [31:0] wa;
        logic [31:0] er2; logic ee; int el, ew;
        modelTxn(1'b1, 3'd2, 32'h3FC, 32'hDEADBEEF, er2, ee, el, ew);
        applyStimulus(1'b1, 3'd2, 32'h3FC, 32'hDEADBEEF, rd, er, lat, wc, wcy, wa, rb);
        checkCount += 3;
        if (wc !== 1 || wcy !== 1) $display("[TB] FAIL sw_we got pulses=%0d cycle=%0d want 1/1", wc, wcy); else passCount++;
        if (wa !== 32'd255) $display("[TB] FAIL sw_mem_addr got %0d want 255", wa); else passCount++;
        if (lat !== 2) $display("[TB] FAIL sw_latency got %0d want 2", lat); else passCount++;
        modelTxn(1'b0, 3'd2, 32'h3FC, 32'h0, er2, ee, el, ew);
        applyStimulus(1'b0, 3'd2, 32'h3FC, 32'h0, rd, er, lat, wc, wcy, wa, rb);
        checkCount += 1;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("[TB] FAIL lw_top got %h err=%0b want DEADBEEF err=0", rd, er); else passCount++;
        modelTxn(1'b0, 3'd2, 32'h400, 32'h0, er2, ee, el, ew);
        applyStimulus(1'b0, 3'd2, 32'h400, 32'h0, rd, er, lat, wc, wcy, wa, rb);
        checkCount += 3;
        if (er !== 1'b1 || rd !== 32'h0) $display("[TB] FAIL lw_range got err=%0b rdata=%h want 1/0", er, rd); else passCount++;
        if (lat !== 1) $display("[TB] FAIL lw_range_latency got %0d want 1", lat); else passCount++;
        if (wc !== 0) $display("[TB] FAIL lw_range_mem_we got %0d pulses want 0", wc); else passCount++;
        applyStimulus(1'b1, 3'd2, 32'h400, 32'h12345678, rd, er, lat, wc, wcy, wa, rb);
        checkCount += 1;
        if (er !== 1'b1 || wc !== 0) $display("[TB] FAIL sw_range got err=%0b pulses=%0d want 1/0", er, wc); else passCount++;
    endtask

    task automatic test_align();
        logic [31:0] rd; logic er; int lat, wc, wcy, rb; logic [31:0] wa;
        logic [31:0] er2; logic ee; int el, ew;
        modelTxn(1'b0, 3'd2, 32'h15, 32'h0, er2, ee, el, ew);
        applyStimulus(1'b0, 3'd2, 32'h15, 32'h0, rd, er, lat, wc, wcy, wa, rb);
        checkCount += 2;
`ifdef LSU_ALIGN_CHECK_EN
        if (er !== 1'b1 || rd !== 32'h0) $display("[TB] FAIL lw_misaligned got err=%0b rdata=%h want 1/0", er, rd); else passCount++;
        if (lat !== 1) $display("[TB] FAIL lw_misaligned_latency got %0d want 1", lat); else passCount++;
`else
        if (er !== 1'b0 || rd !== 32'h5A811234) $display("[TB] FAIL lw_unaligned got err=%0b rdata=%h want 0/5A811234", er, rd); else passCount++;
        if (lat !== 2) $display("[TB] FAIL lw_unaligned_latency got %0d want 2", lat); else passCount++;
`endif
    endtask

    task automatic test_reset_mid_write();
        int sawResp;
        sawResp = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h17;
        req_wdata  = 32'h000000C3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        checkCount += 1;
        if (mem_we !== 1'b1) $display("[TB] FAIL abort_in_write got mem_we=%0b want 1", mem_we); else passCount++;
        rst = 1'b1;
        #1;
        checkCount += 2;
        if (mem_we !== 1'b0) $display("[TB] FAIL abort_mem_we got %0b want 0", mem_we); else passCount++;
        if (resp_valid !== 1'b0) $display("[TB] FAIL abort_resp_valid got %0b want 0", resp_valid); else passCount++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkCount += 2;
        if (req_ready !== 1'b1) $display("[TB] FAIL abort_req_ready got %0b want 1", req_ready); else passCount++;
        if (mem[5] !== 32'h5A811234) $display("[TB] FAIL abort_mem_word got %h want 5A811234", mem[5]); else passCount++;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) sawResp++;
        end
        checkCount += 1;
        if (sawResp !== 0) $display("[TB] FAIL abort_no_resp got %0d pulses want 0", sawResp); else passCount++;
    endtask

    // Back-to-back random traffic over a small window plus the top word and out-of-range addresses.
    task automatic test_random_back_to_back();
        logic [31:0] rd; logic er; int lat, wc, wcy, rb; logic [31:0] wa;
        logic [31:0] expRd; logic expEr; int expLat, expWc;
        logic we; logic [2:0] f3; logic [31:0] addr, wdata;
        int idx;
        for (int n = 0; n < 60; n++) begin
            we    = $urandom_range(0, 1) == 1;
            f3    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       idx = 255;
                1:       idx = $urandom_range(256, 300);
                default: idx = $urandom_range(0, 15);
            endcase
            addr  = {idx[29:0], 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 19) == 0) addr = $urandom | 32'h8000_0000;
            wdata = $urandom;
            modelTxn(we, f3, addr, wdata, expRd, expEr, expLat, expWc);
            applyStimulus(we, f3, addr, wdata, rd, er, lat, wc, wcy, wa, rb);
            checkCount += 5;
            if (er !== expEr) $display("[TB] FAIL rnd%0d_err we=%0b f3=%0d addr=%h got %0b want %0b", n, we, f3, addr, er, expEr); else passCount++;
            if (rd !== expRd) $display("[TB] FAIL rnd%0d_rdata we=%0b f3=%0d addr=%h got %h want %h", n, we, f3, addr, rd, expRd); else passCount++;
            if (lat !== expLat) $display("[TB] FAIL rnd%0d_latency got %0d want %0d", n, lat, expLat); else passCount++;
            if (wc !== expWc) $display("[TB] FAIL rnd%0d_we_pulses got %0d want %0d", n, wc, expWc); else passCount++;
            if (rb !== 0) $display("[TB] FAIL rnd%0d_ready_busy got %0d want 0", n, rb); else passCount++;
            if (we && !expEr) begin
                idx = int'(addr >> 2);
                #1;
                checkCount += 1;
                if (mem[idx] !== refMem[idx]) $display("[TB] FAIL rnd%0d_mem word %0d got %h want %h", n, idx, mem[idx], refMem[idx]); else passCount++;
            end
        end
    endtask

    initial begin
        passCount   = 0;
        checkCount  = 0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_funct3  = 3'd0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        preloadEn   = 1'b0;
        clearEn     = 1'b0;
        preloadIdx  = 8'h0;
        preloadData = 32'h0;
        test_reset();
        clearMem();
        test_loads();
        test_subword_stores();
        test_range();
        test_align();
        test_reset_mid_write();
        test_random_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
